// File: rtl/control_sequencer.sv
// Hardwired control sequencer: steps T0..T6 and decodes the opcode in ir into datapath strobes.
// Optional MEM_WAIT_EN adds mem_ready; while it is low, T1 holds with its strobes asserted.
module control_sequencer #(
  parameter int unsigned T_LAST_MAX = 6
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic [15:0] rin,
  output logic [15:0] rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic [3:0]  ALUselect,
  output logic        done,
  output logic        fault
`ifdef MEM_WAIT_EN
  ,
  input  logic        mem_ready
`endif
);

  localparam int unsigned STEP_W = $clog2(T_LAST_MAX + 1);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] T6 = STEP_W'(T_LAST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;
  typedef enum logic [1:0] {C_BAD, C_ALU3, C_MULDIV, C_UNARY} cls_t;

  state_t            state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [STEP_W-1:0] last_step;
  logic              hold;
  cls_t              cls;
  logic [3:0]        alu_code;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  // Instruction class and ALU operation for the current opcode
  always_comb begin
    cls      = C_BAD;
    alu_code = 4'b0000;
    case (opcode)
      5'b00011: begin cls = C_ALU3;   alu_code = 4'b0001; end
      5'b00100: begin cls = C_ALU3;   alu_code = 4'b0010; end
      5'b00101: begin cls = C_ALU3;   alu_code = 4'b0011; end
      5'b00110: begin cls = C_ALU3;   alu_code = 4'b0100; end
      5'b00111: begin cls = C_ALU3;   alu_code = 4'b0101; end
      5'b01000: begin cls = C_ALU3;   alu_code = 4'b1000; end
      5'b01001: begin cls = C_ALU3;   alu_code = 4'b0110; end
      5'b01010: begin cls = C_ALU3;   alu_code = 4'b0111; end
      5'b01110: begin cls = C_MULDIV; alu_code = 4'b1001; end
      5'b01111: begin cls = C_MULDIV; alu_code = 4'b1010; end
      5'b10000: begin cls = C_UNARY;  alu_code = 4'b1011; end
      5'b10001: begin cls = C_UNARY;  alu_code = 4'b1100; end
      default:  begin cls = C_BAD;    alu_code = 4'b0000; end
    endcase
  end

  always_comb begin
    case (cls)
      C_ALU3:  last_step = T5;
      C_UNARY: last_step = T4;
      default: last_step = T6;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= S_IDLE;
      step  <= T0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  // Next-state: fetch steps are common, the opcode selects the last step
  always_comb begin
    state_nx = state;
    step_nx  = step;
`ifdef MEM_WAIT_EN
    hold = (step == T1) && !mem_ready;
`else
    hold = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nx = S_RUN;
          step_nx  = T0;
        end
      end
      S_RUN: begin
        if ((step == T3) && (cls == C_BAD)) begin
          state_nx = S_FAULT;
          step_nx  = T0;
        end else if (step == last_step) begin
          state_nx = run ? S_RUN : S_IDLE;
          step_nx  = T0;
        end else if (!hold) begin
          step_nx = step + STEP_W'(1);
        end
      end
      S_FAULT: begin
        state_nx = S_FAULT;
        step_nx  = T0;
      end
      default: begin
        state_nx = S_IDLE;
        step_nx  = T0;
      end
    endcase
  end

  // Moore strobe decode of state, step and ir
  always_comb begin
    rin       = 16'h0000;
    rout      = 16'h0000;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Read      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    ZLowout   = 1'b0;
    ZHighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    ALUselect = 4'b0000;
    done      = 1'b0;
    fault     = (state == S_FAULT);
    if (state == S_RUN) begin
      case (step)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          case (cls)
            C_ALU3:   begin rout = 16'h0001 << rb; Yin = 1'b1; end
            C_MULDIV: begin rout = 16'h0001 << ra; Yin = 1'b1; end
            C_UNARY:  begin rout = 16'h0001 << rb; Zin = 1'b1; ALUselect = alu_code; end
            default:  ;
          endcase
        end
        T4: begin
          case (cls)
            C_ALU3:   begin rout = 16'h0001 << rc; Zin = 1'b1; ALUselect = alu_code; end
            C_MULDIV: begin rout = 16'h0001 << rb; Zin = 1'b1; ALUselect = alu_code; end
            C_UNARY:  begin ZLowout = 1'b1; rin = 16'h0001 << ra; done = 1'b1; end
            default:  ;
          endcase
        end
        T5: begin
          case (cls)
            C_ALU3:   begin ZLowout = 1'b1; rin = 16'h0001 << ra; done = 1'b1; end
            C_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; end
            default:  ;
          endcase
        end
        T6: begin
          if (cls == C_MULDIV) begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the datapath; generates the per-step control strobes (R*in/R*out, PCout, MARin, IncPC, Zin, MDRin/MDRout, IRin, Yin, ZLowout/ZHighout, HIin/LOin, Read, ALUselect).
- Decodes the instruction held in the datapath IR.
- Steps T0..T6 automatically, one cycle per step; drives the control side of the interface that the datapath consumes.

Parameters:
- T_LAST_MAX, 6, index of the longest step (mul/div use T0..T6).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- clear  input  1  synchronous active-high reset
- run  input  1  level; 1 permits fetch of next instruction from IDLE
- ir  input  32  datapath IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- rin  output  16  one-hot register load strobes, bit n = RnIn
- rout  output  16  one-hot register drive strobes, bit n = RnOut
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, ZLowout, ZHighout, HIin, LOin  output  1 each  datapath strobes
- ALUselect  output  4  ALU operation
- done  output  1  one-cycle pulse in final step of an instruction
- fault  output  1  sticky illegal-opcode flag

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE and fault=0. All outputs are 0 in IDLE, including ALUselect=0000. Clear has priority over everything and is honoured mid-instruction.
- Outputs are Moore decodes of the state register and ir; they change only after a clk edge. At most one rout bit is set at any time; the same holds for rin.
- IDLE -> T0 when run=1, else stay.
- T0: PCout, MARin, IncPC, Zin.
- T1: ZLowout, PCin, Read, MDRin.
- T2: MDRout, IRin. The datapath IR loads at the T2 edge, so ir is valid from T3 onward.
- Three-operand class (add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010):
  - T3: rout[Rb], Yin.
  - T4: rout[Rc], Zin, ALUselect=op code.
  - T5: ZLowout, rin[Ra], done. Then back to T0 if run=1, else IDLE.
- mul 01110 / div 01111:
  - T3: rout[Ra], Yin.
  - T4: rout[Rb], Zin, ALUselect.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin, done.
- neg 10000 / not 10001:
  - T3: rout[Rb], Zin, ALUselect.
  - T4: ZLowout, rin[Ra], done.
- ALUselect codes: add 0001, sub 0010, shr 0011, shl 0100, ror 0101, and 0110, or 0111, rol 1000, mul 1001, div 1010, neg 1011, not 1100. Outside the ALU steps, ALUselect=0000.
- Any other opcode seen at T3: go to FAULT. FAULT sets fault=1 with all strobes 0 and stays until clear. done is not pulsed.
- Latency: 6 cycles per instruction for 3-operand ops, 7 for mul/div, 5 for neg/not. Back-to-back instructions run with no IDLE gap while run stays 1.
- run dropping mid-instruction does not abort; the sequencer finishes the current instruction, then enters IDLE.
- ir changing outside T3..T6 is ignored.

Optional Feature:
- Macro MEM_WAIT_EN.
  - Defined: adds input mem_ready (1 bit). T1 holds, with all T1 strobes asserted, until mem_ready=1, then advances to T2. clear still overrides.
  - Undefined: no port; T1 is always exactly one cycle.

Test Plan:
- Reset: clear=1 for 2 cycles during T3 of an add -> next cycle state IDLE, all outputs 0, fault=0.
- and R5,R2,R4 (ir=32'h4A920000), run=1:
  - T3: rout=16'h0004, Yin=1.
  - T4: rout=16'h0010, ALUselect=0110, Zin=1.
  - T5: ZLowout=1, rin=16'h0020, done=1.
  - Total 6 cycles from T0.
- mul R2,R4 (32'h71200000):
  - T3: rout=16'h0004, Yin=1.
  - T4: rout=16'h0010, ALUselect=1001.
  - T5: LOin=1.
  - T6: HIin=1, ZHighout=1, done=1.
- neg R2,R4 (32'h81200000):
  - T3: rout=16'h0010, ALUselect=1011, Zin=1.
  - T4: rin=16'h0004, done=1.
- Illegal opcode 11111 -> fault=1 from the cycle after T3, all strobes 0, persists with run=1 until clear.
- run held 1 across two add instructions -> the T0 of the second follows the T5 of the first directly; run=0 during T4 -> T5 completes, then IDLE with all outputs 0.
